round_robin_scheduler: RTL and testbench
========================================

# round_robin_scheduler

Sequential 16-way arbiter that shares one resource among 16 requesters. Each cycle it resolves the active request lines into a single registered one-hot grant. It searches round-robin from a rotating pointer, so no requester starves. A granted requester keeps ownership until it drops its request line. When compiled in, a hold timeout also ends ownership. It sits between requester request lines and the shared datapath, and replaces direct use of the combinational priority resolver wherever the resource is held for multiple cycles.

## Interface
Parameters:
- MAX_HOLD, 64, cycles a grant may be held before forced release (1..65535); used only with ARB_TIMEOUT_EN.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- arbEnable  input  1  when high, the IDLE state may issue new grants; it never affects a grant already held.
- requestSignals  input  16  bit i high = requester i wants the resource; bit i low while granted = release.
- grantSignals  output  16  registered one-hot grant; all-zero when nobody owns the resource.
- grantValid  output  1  high exactly when grantSignals is nonzero.
- grantIndex  output  4  binary index of the current owner; holds the last owner when grantValid is low.
- timeoutPulse  output  1  one-cycle pulse on a forced release.

## Operation
- Synchronous reset, active-high. On reset:
  - state = IDLE
  - grantSignals = 0, grantValid = 0, grantIndex = 0, timeoutPulse = 0
  - pointer = 0, holdCount = 0
- **IDLE**:
  - If arbEnable = 1 and requestSignals != 0, search indices pointer, pointer+1, …, 15, 0, …, pointer−1.
  - The first set bit i wins. Set grantSignals = 1<<i, grantIndex = i, holdCount = 0, and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**:
  - If requestSignals[grantIndex] = 0, clear the grant, set pointer = (grantIndex+1) mod 16, and go to IDLE.
  - With ARB_TIMEOUT_EN: if the request is still high and holdCount = MAX_HOLD−1, force release. Clear the grant, set pointer = (grantIndex+1) mod 16, pulse timeoutPulse, and go to IDLE. Otherwise increment holdCount.
  - Changes on other request bits are ignored while in GRANT.
- Pointer arithmetic is 4-bit and wraps naturally: owner 15 → pointer 0.
- If all 16 requests are high, the winner is the pointer index.
- A requester that drops and re-raises its request in the IDLE evaluation cycle is treated as a new request; the round-robin order still applies.

## Timing
- Request to grant: a request sampled at edge t in IDLE gives grantSignals valid after edge t (1-cycle latency).
- Release to grant low: a request low sampled at edge t gives grant low after edge t.
- Every release is followed by at least one cycle of grantValid = 0 (the IDLE evaluation cycle). The earliest next grant is after edge t+1.
- Minimum ownership is 1 cycle.
- With ARB_TIMEOUT_EN, ownership lasts at most MAX_HOLD cycles.
- timeoutPulse is high for exactly the one cycle in which grantValid first returns to 0 after a forced release.
- grantSignals, grantValid and grantIndex change only on clock edges.
- grantValid always equals |grantSignals.
- Reset asserted mid-grant: grant is 0 after that edge, pointer = 0, no timeoutPulse.

## Configuration
- ARB_TIMEOUT_EN defined: holdCount (16-bit) and forced release at MAX_HOLD are compiled in; timeoutPulse is driven as specified.
- ARB_TIMEOUT_EN undefined:
  - No counter is built; ownership is unbounded and ends only on request drop.
  - timeoutPulse is tied to 0.
  - MAX_HOLD is ignored.

## Test plan
- Reset/idle:
  - Assert Reset with requestSignals = 16'hFFFF. Outputs must be grantSignals = 0, grantValid = 0, grantIndex = 0.
  - Release Reset. After the next edge, grantSignals = 16'h0001, grantIndex = 0.
- Round-robin rotation:
  - Hold requestSignals = 16'hFFFF and drop each owner's bit for one cycle after 2 cycles of ownership.
  - Grants must go 0,1,2,…,15,0, each separated by exactly one grantValid = 0 cycle.
- Wrap and skip:
  - Owner 13 releases while requestSignals = 16'h2005. Next grant is index 0 (16'h0001); the following one is index 2.
- Hold and ignore:
  - Requester 4 granted; toggle other bits randomly for 20 cycles.
  - grantSignals must stay 16'h0010 until bit 4 drops, then be 0 after the next edge.
- arbEnable gating:
  - arbEnable = 0 with requestSignals = 16'h0100 → no grant for 10 cycles.
  - Raise arbEnable → grantSignals = 16'h0100 one edge later.
  - Lowering arbEnable mid-grant does not clear the grant.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD = 4):
  - Requester 7 holds its request continuously. Grant is high for exactly 4 cycles, then grantValid = 0 and timeoutPulse = 1 for 1 cycle.
  - Requester 7 is re-granted next only if it is the sole request; with requestSignals = 16'h0180, requester 8 wins.
  - Without the macro, the grant persists 100+ cycles and timeoutPulse stays 0.

Source files
------------

// File: rtl/round_robin_scheduler.sv
// 16-way round-robin arbiter with registered one-hot grant held until the owner releases.
// Optional hold timeout compiled in with `define ARB_TIMEOUT_EN (limit set by MAX_HOLD).
module round_robin_scheduler #(
  parameter int MAX_HOLD = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        arbEnable,
  input  logic [15:0] requestSignals,
  output logic [15:0] grantSignals,
  output logic        grantValid,
  output logic [3:0]  grantIndex,
  output logic        timeoutPulse
);

  typedef enum logic {IDLE, GRANT} state_t;

  if (MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_max_hold
    $error("MAX_HOLD out of range 1..65535");
  end

  state_t      state_q, state_d;
  logic [15:0] grant_q, grant_d;
  logic        valid_q, valid_d;
  logic [3:0]  index_q, index_d;
  logic [3:0]  pointer_q, pointer_d;
  logic        timeout_q, timeout_d;
`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
  logic [15:0] hold_q, hold_d;
`endif

  // Round-robin search: first set request at or after the pointer, wrapping at 15.
  logic [3:0] win_idx;
  logic       win_found;
  logic [3:0] cand;
  always_comb begin
    win_idx   = pointer_q;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < 16; k++) begin
      cand = pointer_q + 4'(k);
      if (!win_found && requestSignals[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    index_d   = index_q;
    pointer_d = pointer_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (arbEnable && win_found) begin
          grant_d = 16'(1) << win_idx;
          valid_d = 1'b1;
          index_d = win_idx;
          state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (!requestSignals[index_q]) begin
          grant_d   = '0;
          valid_d   = 1'b0;
          pointer_d = index_q + 4'd1;
          state_d   = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          grant_d   = '0;
          valid_d   = 1'b0;
          pointer_d = index_q + 4'd1;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          hold_d = hold_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      index_q   <= '0;
      pointer_q <= '0;
      timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      index_q   <= index_d;
      pointer_q <= pointer_d;
      timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign grantSignals = grant_q;
  assign grantValid   = valid_q;
  assign grantIndex   = index_q;
`ifdef ARB_TIMEOUT_EN
  assign timeoutPulse = timeout_q;
`else
  assign timeoutPulse = 1'b0;
  logic unused_timeout;
  assign unused_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_round_robin_scheduler.sv
// Self-checking bench for round_robin_scheduler: directed scenarios plus random traffic
// compared against a behavioural owner/pointer model.
module tb_round_robin_scheduler;

  localparam int MAXH = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        arbEnable = 1'b0;
  logic [15:0] requestSignals = '0;
  logic [15:0] grantSignals;
  logic        grantValid;
  logic [3:0]  grantIndex;
  logic        timeoutPulse;

  int n_checks = 0;
  int n_fail   = 0;

  round_robin_scheduler #(.MAX_HOLD(MAXH)) dut (
    .Clk(Clk), .Reset(Reset), .arbEnable(arbEnable),
    .requestSignals(requestSignals), .grantSignals(grantSignals),
    .grantValid(grantValid), .grantIndex(grantIndex), .timeoutPulse(timeoutPulse)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: who owns the resource, where the search starts next, how long held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_last  = 0;
  bit m_pulse = 0;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  task automatic model_update();
    if (Reset) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_last = 0; m_pulse = 0;
    end else if (m_owner < 0) begin
      m_pulse = 0;
      if (arbEnable && requestSignals != 0) begin
        for (int k = 0; k < 16; k++) begin
          int i;
          i = (m_ptr + k) % 16;
          if (m_owner < 0 && requestSignals[i]) m_owner = i;
        end
        m_last = m_owner;
        m_hold = 0;
      end
    end else begin
      m_pulse = 0;
      if (!requestSignals[m_owner]) begin
        m_ptr = (m_owner + 1) % 16;
        m_owner = -1;
      end else if (TIMEOUT_ON && m_hold == MAXH - 1) begin
        m_ptr = (m_owner + 1) % 16;
        m_owner = -1;
        m_pulse = 1;
      end else begin
        m_hold++;
      end
    end
  endtask

  function automatic logic [21:0] exp_vec();
    logic [15:0] g;
    g = (m_owner >= 0) ? (16'(1) << m_owner) : 16'h0;
    return {g, (m_owner >= 0), 4'(m_last), m_pulse};
  endfunction

  function automatic logic [21:0] act_vec();
    return {grantSignals, grantValid, grantIndex, timeoutPulse};
  endfunction

  // Inputs change only at #1 after an edge; outputs are sampled at the same point.
  task automatic step();
    model_update();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; arbEnable = 1'b1; requestSignals = 16'hFFFF;
    step();
    n_checks++;
    if ({grantSignals, grantValid, grantIndex, timeoutPulse} !== 22'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", act_vec(), 22'h0);
    end
    Reset = 1'b0;
    step();
    n_checks++;
    if (grantSignals !== 16'h0001 || grantIndex !== 4'd0 || grantValid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: got g=%h i=%0d v=%b want g=0001 i=0 v=1",
               grantSignals, grantIndex, grantValid);
    end
  endtask

  task automatic test_rotation();
    logic [15:0] want;
    for (int n = 0; n < 16; n++) begin
      step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rotation_hold[%0d]: got %h want %h", n, act_vec(), exp_vec());
      end
      requestSignals = 16'hFFFF & ~(16'(1) << n);
      step();
      n_checks++;
      if (grantValid !== 1'b0 || grantSignals !== 16'h0) begin
        n_fail++;
        $display("FAIL rotation_gap[%0d]: got g=%h v=%b want g=0000 v=0", n, grantSignals, grantValid);
      end
      requestSignals = 16'hFFFF;
      step();
      want = 16'(1) << ((n + 1) % 16);
      n_checks++;
      if (grantSignals !== want || grantIndex !== 4'((n + 1) % 16)) begin
        n_fail++;
        $display("FAIL rotation_next[%0d]: got g=%h i=%0d want g=%h", n, grantSignals, grantIndex, want);
      end
    end
  endtask

  task automatic test_wrap_skip();
    Reset = 1'b1; arbEnable = 1'b1; requestSignals = 16'h2000;
    step();
    Reset = 1'b0;
    step();
    n_checks++;
    if (grantSignals !== 16'h2000 || grantIndex !== 4'd13) begin
      n_fail++;
      $display("FAIL wrap_owner13: got g=%h i=%0d want g=2000 i=13", grantSignals, grantIndex);
    end
    requestSignals = 16'h0005;
    step();
    requestSignals = 16'h2005;
    step();
    n_checks++;
    if (grantSignals !== 16'h0001 || grantIndex !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_to_0: got g=%h i=%0d want g=0001 i=0", grantSignals, grantIndex);
    end
    requestSignals = 16'h2004;
    step();
    step();
    n_checks++;
    if (grantSignals !== 16'h0004 || act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL skip_to_2: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_hold_ignore();
    Reset = 1'b1; arbEnable = 1'b1; requestSignals = 16'h0010;
    step();
    Reset = 1'b0;
    step();
    for (int c = 0; c < 20; c++) begin
      requestSignals = 16'($urandom) | 16'h0010;
      step();
      n_checks++;
      if (act_vec() !== exp_vec() || (!TIMEOUT_ON && grantSignals !== 16'h0010)) begin
        n_fail++;
        $display("FAIL hold_ignore[%0d]: got %h want %h", c, act_vec(), exp_vec());
      end
    end
    requestSignals = 16'($urandom) & ~16'h0010;
    step();
    n_checks++;
    if (grantSignals !== 16'h0 || grantValid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: got g=%h v=%b want g=0000 v=0", grantSignals, grantValid);
    end
  endtask

  task automatic test_enable();
    Reset = 1'b1; arbEnable = 1'b0; requestSignals = 16'h0100;
    step();
    Reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (grantSignals !== 16'h0 || grantValid !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_gated[%0d]: got g=%h want g=0000", c, grantSignals);
      end
    end
    arbEnable = 1'b1;
    step();
    n_checks++;
    if (grantSignals !== 16'h0100 || grantIndex !== 4'd8) begin
      n_fail++;
      $display("FAIL enable_grant: got g=%h i=%0d want g=0100 i=8", grantSignals, grantIndex);
    end
    arbEnable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (grantSignals !== 16'h0100) begin
        n_fail++;
        $display("FAIL enable_keep[%0d]: got g=%h want g=0100", c, grantSignals);
      end
    end
  endtask

  task automatic test_timeout();
    Reset = 1'b1; arbEnable = 1'b1; requestSignals = 16'h0080;
    step();
    Reset = 1'b0;
    step();
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < MAXH - 1; c++) step();
    n_checks++;
    if (grantSignals !== 16'h0080 || timeoutPulse !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_last_cycle: got g=%h to=%b want g=0080 to=0", grantSignals, timeoutPulse);
    end
    step();
    n_checks++;
    if (grantValid !== 1'b0 || timeoutPulse !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_release: got v=%b to=%b want v=0 to=1", grantValid, timeoutPulse);
    end
    requestSignals = 16'h0180;
    step();
    n_checks++;
    if (grantSignals !== 16'h0100 || timeoutPulse !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_next_owner: got g=%h to=%b want g=0100 to=0", grantSignals, timeoutPulse);
    end
`else
    for (int c = 0; c < 120; c++) begin
      step();
      n_checks++;
      if (grantSignals !== 16'h0080 || timeoutPulse !== 1'b0) begin
        n_fail++;
        $display("FAIL no_timeout[%0d]: got g=%h to=%b want g=0080 to=0", c, grantSignals, timeoutPulse);
      end
    end
`endif
  endtask

  task automatic test_random();
    Reset = 1'b1; arbEnable = 1'b1; requestSignals = '0;
    step();
    Reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) requestSignals = 16'($urandom) & 16'($urandom);
      arbEnable = ($urandom_range(0, 7) != 0);
      Reset = ($urandom_range(0, 63) == 0);
      step();
      n_checks++;
      if (act_vec() !== exp_vec() || grantValid !== (|grantSignals)) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", c, act_vec(), exp_vec());
      end
    end
    Reset = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_hold_ignore();
    test_enable();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
